// File: rtl/sparce_pkg.sv
// Shared types and constants for the SASA skip table: field layout of the
// configuration word, register offsets and the table entry record.
package sparce_pkg;

    typedef enum logic [1:0] {
        COND_EQ = 2'd0,
        COND_NE = 2'd1,
        COND_LT = 2'd2,
        COND_GE = 2'd3
    } sasa_cond_t;

    typedef enum logic {
        CFG_IDLE,
        CFG_PC_HELD
    } cfg_state_t;

    localparam logic [31:0] SASA_OFF_PC    = 32'h0;
    localparam logic [31:0] SASA_OFF_FIELD = 32'h4;
    localparam logic [31:0] SASA_OFF_CLEAR = 32'h8;

    localparam int SKIP_MSB = 31;
    localparam int SKIP_LSB = 16;
    localparam int RS1_MSB  = 15;
    localparam int RS1_LSB  = 11;
    localparam int RS2_MSB  = 10;
    localparam int RS2_LSB  = 6;
    localparam int COND_MSB = 5;
    localparam int COND_LSB = 4;

    typedef struct packed {
        logic        entry_valid;
        logic [31:0] preceding_pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        sasa_cond_t  condition;
        logic [15:0] insts_to_skip;
    } sasa_entry_t;

    // Bits [3:0] of the field word carry nothing and are dropped here.
    function automatic sasa_entry_t make_entry(input logic [31:0] pc_word,
                                               input logic [31:0] field_word);
        sasa_entry_t e;
        e.entry_valid   = 1'b1;
        e.preceding_pc  = pc_word;
        e.rs1           = field_word[RS1_MSB:RS1_LSB];
        e.rs2           = field_word[RS2_MSB:RS2_LSB];
        e.condition     = sasa_cond_t'(field_word[COND_MSB:COND_LSB]);
        e.insts_to_skip = field_word[SKIP_MSB:SKIP_LSB];
        return e;
    endfunction

endpackage

// File: rtl/sparce_sasa_cfg.sv
// Configuration-window decoder: stages the PC word, then commits a full entry
// when the field word arrives, choosing an in-place update or round-robin slot.
module sparce_sasa_cfg
    import sparce_pkg::*;
#(
    parameter int          ENTRIES = 16,
    parameter logic [31:0] BASE    = 32'h9000_0000,
    localparam int         IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               cfg_addr,
    input  logic [31:0]               cfg_data,
    input  logic                      cfg_wen,
    input  logic [ENTRIES-1:0]        tbl_valid,
    input  logic [ENTRIES-1:0][31:0]  tbl_pc,
    output logic                      commit,
    output logic [IDX_W-1:0]          commit_idx,
    output sasa_entry_t               commit_entry,
    output logic                      clear
);

    cfg_state_t       state_q, state_d;
    logic [31:0]      staging_pc_q, staging_pc_d;
    logic [IDX_W-1:0] alloc_ptr_q, alloc_ptr_d;

    logic             wr_pc, wr_field, wr_clear;
    logic             match_found;
    logic [IDX_W-1:0] match_idx;

    assign wr_pc    = cfg_wen && (cfg_addr == BASE + SASA_OFF_PC);
    assign wr_field = cfg_wen && (cfg_addr == BASE + SASA_OFF_FIELD);
    assign wr_clear = cfg_wen && (cfg_addr == BASE + SASA_OFF_CLEAR);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_valid[i] && (tbl_pc[i] == staging_pc_q)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        staging_pc_d = staging_pc_q;
        alloc_ptr_d  = alloc_ptr_q;
        commit       = 1'b0;
        clear        = 1'b0;
        commit_idx   = alloc_ptr_q;
        commit_entry = make_entry(staging_pc_q, cfg_data);

        if (wr_clear) begin
            clear       = 1'b1;
            alloc_ptr_d = '0;
            state_d     = CFG_IDLE;
        end else if (wr_pc) begin
            staging_pc_d = cfg_data;
            state_d      = CFG_PC_HELD;
        end else if (wr_field && (state_q == CFG_PC_HELD)) begin
            commit  = 1'b1;
            state_d = CFG_IDLE;
            if (match_found) begin
                commit_idx = match_idx;
            end else begin
                alloc_ptr_d = alloc_ptr_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CFG_IDLE;
            staging_pc_q <= '0;
            alloc_ptr_q  <= '0;
        end else begin
            state_q      <= state_d;
            staging_pc_q <= staging_pc_d;
            alloc_ptr_q  <= alloc_ptr_d;
        end
    end

endmodule

// File: rtl/sparce_sasa_table.sv
// SASA skip table: holds committed entries and performs a zero-latency,
// lowest-index-wins PC lookup against them.
module sparce_sasa_table
    import sparce_pkg::*;
#(
    parameter int          SASA_ENTRIES = 16,
    parameter logic [31:0] SASA_BASE    = 32'h9000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc,
    input  logic [31:0] sasa_addr,
    input  logic [31:0] sasa_data,
    input  logic        sasa_wen,
    input  logic        sasa_enable,
    output logic        valid,
    output logic [31:0] preceding_pc,
    output logic [4:0]  sasa_rs1,
    output logic [4:0]  sasa_rs2,
    output logic [1:0]  condition,
    output logic [15:0] insts_to_skip
);

    localparam int IDX_W = (SASA_ENTRIES > 1) ? $clog2(SASA_ENTRIES) : 1;

    sasa_entry_t table_q [SASA_ENTRIES];
    sasa_entry_t table_d [SASA_ENTRIES];

    logic [SASA_ENTRIES-1:0]       tbl_valid;
    logic [SASA_ENTRIES-1:0][31:0] tbl_pc;

    logic             commit, clear;
    logic [IDX_W-1:0] commit_idx;
    sasa_entry_t      commit_entry;

    logic             hit;
    sasa_entry_t      hit_entry;

    always_comb begin
        for (int i = 0; i < SASA_ENTRIES; i++) begin
            tbl_valid[i] = table_q[i].entry_valid;
            tbl_pc[i]    = table_q[i].preceding_pc;
        end
    end

    sparce_sasa_cfg #(
        .ENTRIES (SASA_ENTRIES),
        .BASE    (SASA_BASE)
    ) u_cfg (
        .clk          (CLK),
        .rst_n        (nRST),
        .cfg_addr     (sasa_addr),
        .cfg_data     (sasa_data),
        .cfg_wen      (sasa_wen),
        .tbl_valid    (tbl_valid),
        .tbl_pc       (tbl_pc),
        .commit       (commit),
        .commit_idx   (commit_idx),
        .commit_entry (commit_entry),
        .clear        (clear)
    );

    always_comb begin
        for (int i = 0; i < SASA_ENTRIES; i++) begin
            table_d[i] = table_q[i];
            if (clear) begin
                table_d[i] = '0;
            end else if (commit && (commit_idx == IDX_W'(i))) begin
                table_d[i] = commit_entry;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SASA_ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SASA_ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    // Lookup reads registered contents only, so a same-cycle commit is not yet visible.
    always_comb begin
        hit       = 1'b0;
        hit_entry = '0;
        for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
            if (table_q[i].entry_valid && (table_q[i].preceding_pc == pc)) begin
                hit       = 1'b1;
                hit_entry = table_q[i];
            end
        end
    end

    always_comb begin
        valid         = 1'b0;
        preceding_pc  = '0;
        sasa_rs1      = '0;
        sasa_rs2      = '0;
        condition     = '0;
        insts_to_skip = '0;
        if (sasa_enable && hit) begin
            valid         = 1'b1;
            preceding_pc  = hit_entry.preceding_pc;
            sasa_rs1      = hit_entry.rs1;
            sasa_rs2      = hit_entry.rs2;
            condition     = hit_entry.condition;
            insts_to_skip = hit_entry.insts_to_skip;
        end
    end

endmodule

// File: tb/tb_sparce_sasa_table.sv
// Self-checking bench for sparce_sasa_table: table-driven lookups scored
// through an expectation queue, plus sequences for eviction, reset and clear.
module tb_sparce_sasa_table;

    localparam logic [31:0] BASE      = 32'h9000_0000;
    localparam logic [31:0] OFF_PC    = 32'h0;
    localparam logic [31:0] OFF_FIELD = 32'h4;
    localparam logic [31:0] OFF_CLEAR = 32'h8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] sasa_addr = '0;
    logic [31:0] sasa_data = '0;
    logic        sasa_wen = 1'b0;
    logic        sasa_enable = 1'b0;
    logic        valid;
    logic [31:0] preceding_pc;
    logic [4:0]  sasa_rs1, sasa_rs2;
    logic [1:0]  condition;
    logic [15:0] insts_to_skip;

    int checks = 0;
    int passes = 0;
    int lookup_id = 0;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
        logic [1:0]  exp_cond;
        logic [15:0] exp_skip;
    } vec_t;

    vec_t sb_q[$];

    sparce_sasa_table #(
        .SASA_ENTRIES (16),
        .SASA_BASE    (BASE)
    ) dut (
        .CLK           (clk),
        .nRST          (rst_n),
        .pc            (pc),
        .sasa_addr     (sasa_addr),
        .sasa_data     (sasa_data),
        .sasa_wen      (sasa_wen),
        .sasa_enable   (sasa_enable),
        .valid         (valid),
        .preceding_pc  (preceding_pc),
        .sasa_rs1      (sasa_rs1),
        .sasa_rs2      (sasa_rs2),
        .condition     (condition),
        .insts_to_skip (insts_to_skip)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the test finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t hitv(input logic [31:0] p, input logic [15:0] skip,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [1:0] c);
        vec_t v;
        v.pc = p; v.en = 1'b1; v.exp_valid = 1'b1; v.exp_pc = p;
        v.exp_rs1 = r1; v.exp_rs2 = r2; v.exp_cond = c; v.exp_skip = skip;
        return v;
    endfunction

    function automatic vec_t missv(input logic [31:0] p, input logic en);
        vec_t v;
        v.pc = p; v.en = en; v.exp_valid = 1'b0; v.exp_pc = '0;
        v.exp_rs1 = '0; v.exp_rs2 = '0; v.exp_cond = '0; v.exp_skip = '0;
        return v;
    endfunction

    function automatic logic [31:0] fw(input logic [15:0] skip, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [1:0] c);
        return {skip, r1, r2, c, 4'hA};
    endfunction

    task automatic check_output();
        vec_t e;
        logic [60:0] got, exp;
        checks++;
        lookup_id++;
        if (sb_q.size() == 0) begin
            $display("[TB] FAIL lookup%0d scoreboard empty", lookup_id);
        end else begin
            e   = sb_q.pop_front();
            got = {valid, preceding_pc, sasa_rs1, sasa_rs2, condition, insts_to_skip};
            exp = {e.exp_valid, e.exp_pc, e.exp_rs1, e.exp_rs2, e.exp_cond, e.exp_skip};
            if (got === exp) passes++;
            else $display("[TB] FAIL lookup%0d pc=%h got %h expected %h",
                          lookup_id, e.pc, got, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        pc          = v.pc;
        sasa_enable = v.en;
        sb_q.push_back(v);
        #1;
        check_output();
    endtask

    task automatic cfg_write(input logic [31:0] off, input logic [31:0] data);
        @(negedge clk);
        sasa_addr = BASE + off;
        sasa_data = data;
        sasa_wen  = 1'b1;
        @(posedge clk);
        #1;
        sasa_wen  = 1'b0;
        sasa_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        sasa_wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t basic_tbl[5];

    initial begin
        basic_tbl[0] = hitv(32'h100, 16'd3, 5'd1, 5'd1, 2'd0);
        basic_tbl[1] = missv(32'h104, 1'b1);
        basic_tbl[2] = missv(32'h100, 1'b0);
        basic_tbl[3] = missv(32'h0, 1'b1);
        basic_tbl[4] = hitv(32'h100, 16'd3, 5'd1, 5'd1, 2'd0);

        // Outputs held at zero while reset is asserted and right after release.
        rst_n = 1'b0;
        apply_stimulus(missv(32'h0, 1'b1));
        rst_n = 1'b1;
        apply_stimulus(missv(32'h0, 1'b1));

        // Basic commit with an unmapped write slipped in between.
        cfg_write(OFF_PC, 32'h100);
        cfg_write(32'hC, 32'hDEAD_BEEF);
        cfg_write(32'h10, 32'h104);
        cfg_write(OFF_FIELD, 32'h0003_0845);
        for (int i = 0; i < 5; i++) apply_stimulus(basic_tbl[i]);

        // Field write in IDLE is ignored.
        cfg_write(OFF_CLEAR, 32'h0);
        cfg_write(OFF_FIELD, fw(16'd9, 5'd2, 5'd3, 2'd1));
        apply_stimulus(missv(32'h100, 1'b1));
        apply_stimulus(missv(32'h0, 1'b1));

        // Reset in PC_HELD discards the staged PC.
        cfg_write(OFF_PC, 32'h200);
        do_reset();
        cfg_write(OFF_FIELD, fw(16'd7, 5'd4, 5'd5, 2'd2));
        apply_stimulus(missv(32'h200, 1'b1));
        apply_stimulus(missv(32'h0, 1'b1));

        // Fill all 16 slots, then a 17th evicts slot 0.
        for (int i = 0; i < 16; i++) begin
            cfg_write(OFF_PC, 32'h1000 + 32'(4 * i));
            cfg_write(OFF_FIELD, fw(16'(i), 5'(i), 5'(31 - i), 2'(i)));
        end
        apply_stimulus(hitv(32'h1000, 16'd0, 5'd0, 5'd31, 2'd0));
        apply_stimulus(hitv(32'h103C, 16'd15, 5'd15, 5'd16, 2'd3));
        cfg_write(OFF_PC, 32'h2000);
        cfg_write(OFF_FIELD, fw(16'h1234, 5'd30, 5'd29, 2'd3));
        apply_stimulus(missv(32'h1000, 1'b1));
        apply_stimulus(hitv(32'h2000, 16'h1234, 5'd30, 5'd29, 2'd3));
        apply_stimulus(hitv(32'h1004, 16'd1, 5'd1, 5'd30, 2'd1));

        // In-place update of the 2nd PC must not advance the pointer.
        cfg_write(OFF_PC, 32'h1004);
        cfg_write(OFF_FIELD, fw(16'h0055, 5'd7, 5'd8, 2'd2));
        apply_stimulus(hitv(32'h1004, 16'h0055, 5'd7, 5'd8, 2'd2));
        apply_stimulus(hitv(32'h1008, 16'd2, 5'd2, 5'd29, 2'd2));
        cfg_write(OFF_PC, 32'h3000);
        cfg_write(OFF_FIELD, fw(16'h0BEE, 5'd9, 5'd10, 2'd1));
        apply_stimulus(missv(32'h1004, 1'b1));
        apply_stimulus(hitv(32'h1008, 16'd2, 5'd2, 5'd29, 2'd2));
        apply_stimulus(hitv(32'h3000, 16'h0BEE, 5'd9, 5'd10, 2'd1));

        // Commit and lookup of the same PC in one cycle.
        cfg_write(OFF_PC, 32'h4000);
        @(negedge clk);
        sasa_addr   = BASE + OFF_FIELD;
        sasa_data   = fw(16'h0042, 5'd11, 5'd12, 2'd3);
        sasa_wen    = 1'b1;
        pc          = 32'h4000;
        sasa_enable = 1'b1;
        sb_q.push_back(missv(32'h4000, 1'b1));
        #1;
        check_output();
        @(posedge clk);
        #1;
        sasa_wen = 1'b0;
        apply_stimulus(hitv(32'h4000, 16'h0042, 5'd11, 5'd12, 2'd3));

        // Clear from PC_HELD: everything misses, FSM back in IDLE.
        cfg_write(OFF_PC, 32'h5000);
        cfg_write(OFF_CLEAR, 32'h0);
        apply_stimulus(missv(32'h4000, 1'b1));
        apply_stimulus(missv(32'h2000, 1'b1));
        apply_stimulus(missv(32'h1008, 1'b1));
        cfg_write(OFF_FIELD, fw(16'd1, 5'd1, 5'd1, 2'd1));
        apply_stimulus(missv(32'h5000, 1'b1));

        // Pointer restarted at 0: 16 new entries then one more evicts the first.
        cfg_write(OFF_PC, 32'h6000);
        cfg_write(OFF_FIELD, fw(16'h0600, 5'd6, 5'd6, 2'd0));
        apply_stimulus(hitv(32'h6000, 16'h0600, 5'd6, 5'd6, 2'd0));
        for (int i = 0; i < 15; i++) begin
            cfg_write(OFF_PC, 32'h7000 + 32'(4 * i));
            cfg_write(OFF_FIELD, fw(16'(i + 100), 5'(i), 5'(i), 2'(i)));
        end
        cfg_write(OFF_PC, 32'h8000);
        cfg_write(OFF_FIELD, fw(16'h0800, 5'd8, 5'd8, 2'd0));
        apply_stimulus(missv(32'h6000, 1'b1));
        apply_stimulus(hitv(32'h7000, 16'd100, 5'd0, 5'd0, 2'd0));
        apply_stimulus(hitv(32'h8000, 16'h0800, 5'd8, 5'd8, 2'd0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
